// File: rtl/vma_mem_req.sv
// vma_mem_req: memory-request sequencer fed by the VMA board.
// Each EBOX memory cycle (START pulse) becomes one of these:
//   - a fast-memory (AC) access,
//   - an MBOX request using the REQ/ACK/DONE handshake,
//   - an address-break trap,
//   - nothing, when neither READ nor WRITE is set.
// A cycle counter aborts an MBOX request that never completes. The abort sets
// the sticky NXM flag and still pulses MEM_DONE, so the EBOX never hangs.
// Ports:
//   clk, RESET_n        clock, async active-low reset
//   START/READ/WRITE    cycle request from MCL (sampled only when idle)
//   VMA/AC_REF/MATCH    latched address, AC decode, address-break compare
//   ABRK_RD/ABRK_WR     address-break enables
//   MB_REQ/ADDR/RD/WR   MBOX request, held stable until MB_ACK
//   MB_ACK/MB_DONE      MBOX handshake inputs
//   FM_SEL/FM_ADR       fast-memory strobe and AC number
//   BUSY/MEM_DONE       sequencer status, one-cycle completion pulse
//   ADR_BRK_TRAP/NXM    sticky error flags, cleared by CLR_ERR
module vma_mem_req #(
  parameter int ADDR_W  = 23,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              RESET_n,
  input  logic              START,
  input  logic              READ,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] VMA,
  input  logic              AC_REF,
  input  logic              MATCH,
  input  logic              ABRK_RD,
  input  logic              ABRK_WR,
  output logic              MB_REQ,
  output logic [ADDR_W-1:0] MB_ADDR,
  output logic              MB_RD,
  output logic              MB_WR,
  input  logic              MB_ACK,
  input  logic              MB_DONE,
  output logic              FM_SEL,
  output logic [3:0]        FM_ADR,
  output logic              BUSY,
  output logic              MEM_DONE,
  output logic              ADR_BRK_TRAP,
  output logic              NXM,
  input  logic              CLR_ERR
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_EXP = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_FM, S_REQ, S_WAIT, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_q, rd_d, wr_q, wr_d;
  logic [3:0]          fm_adr_q, fm_adr_d;
  logic                trap_q, trap_d, nxm_q, nxm_d;
  logic                trap_set, nxm_set, expire, brk;

  // Expiry is judged on the current count, so the request is visible for
  // exactly TIMEOUT cycles before the abort takes effect.
  assign expire = (cnt_q == CNT_EXP);
  assign brk    = MATCH & ((READ & ABRK_RD) | (WRITE & ABRK_WR));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    fm_adr_d = fm_adr_q;
    trap_set = 1'b0;
    nxm_set  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (START && (READ || WRITE)) begin
          addr_d   = VMA;
          rd_d     = READ;
          wr_d     = WRITE;
          fm_adr_d = VMA[3:0];
          if (brk) begin
            trap_set = 1'b1;
          end else if (AC_REF) begin
            state_d = S_FM;
          end else begin
            state_d = S_REQ;
            cnt_d   = '0;
          end
        end
      end
      S_FM: state_d = S_IDLE;
      S_REQ: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        // A completion in the expiry cycle wins over the timeout.
        if (MB_ACK && MB_DONE) begin
          state_d = S_DONE;
        end else if (expire) begin
          nxm_set = 1'b1;
          state_d = S_DONE;
        end else if (MB_ACK) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        if (MB_DONE) begin
          state_d = S_DONE;
        end else if (expire) begin
          nxm_set = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    // A flag being set in the same cycle as CLR_ERR stays set.
    trap_d = trap_set ? 1'b1 : (CLR_ERR ? 1'b0 : trap_q);
    nxm_d  = nxm_set  ? 1'b1 : (CLR_ERR ? 1'b0 : nxm_q);
  end

  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      fm_adr_q <= '0;
      trap_q   <= 1'b0;
      nxm_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      fm_adr_q <= fm_adr_d;
      trap_q   <= trap_d;
      nxm_q    <= nxm_d;
    end
  end

  // Strobes decode from registered state only.
  assign MB_REQ       = (state_q == S_REQ);
  assign FM_SEL       = (state_q == S_FM);
  assign MEM_DONE     = (state_q == S_FM) || (state_q == S_DONE);
  assign BUSY         = (state_q != S_IDLE);
  assign MB_ADDR      = addr_q;
  assign MB_RD        = rd_q;
  assign MB_WR        = wr_q;
  assign FM_ADR       = fm_adr_q;
  assign ADR_BRK_TRAP = trap_q;
  assign NXM          = nxm_q;

endmodule

// File: tb/tb_vma_mem_req.sv
// Bench for vma_mem_req. The expected results for each transaction are
// derived from its kind and its handshake schedule:
//   - which outcome it should produce,
//   - how many cycles the request stays high,
//   - in which cycle MEM_DONE should fire,
//   - how the sticky flags end up.
module tb_vma_mem_req;
  localparam int AW = 23;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          RESET_n;
  logic          START = 0, READ = 0, WRITE = 0, AC_REF = 0, MATCH = 0;
  logic          ABRK_RD = 0, ABRK_WR = 0, MB_ACK = 0, MB_DONE = 0, CLR_ERR = 0;
  logic [AW-1:0] VMA = '0;
  logic          MB_REQ, MB_RD, MB_WR, FM_SEL, BUSY, MEM_DONE, ADR_BRK_TRAP, NXM;
  logic [AW-1:0] MB_ADDR;
  logic [3:0]    FM_ADR;

  vma_mem_req #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .RESET_n(RESET_n), .START(START), .READ(READ), .WRITE(WRITE),
    .VMA(VMA), .AC_REF(AC_REF), .MATCH(MATCH), .ABRK_RD(ABRK_RD), .ABRK_WR(ABRK_WR),
    .MB_REQ(MB_REQ), .MB_ADDR(MB_ADDR), .MB_RD(MB_RD), .MB_WR(MB_WR),
    .MB_ACK(MB_ACK), .MB_DONE(MB_DONE), .FM_SEL(FM_SEL), .FM_ADR(FM_ADR),
    .BUSY(BUSY), .MEM_DONE(MEM_DONE), .ADR_BRK_TRAP(ADR_BRK_TRAP), .NXM(NXM),
    .CLR_ERR(CLR_ERR)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit exp_trap = 0;
  bit exp_nxm  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic rd, input logic wr, input logic [AW-1:0] vma,
                             input logic ac, input logic m, input logic ar, input logic aw);
    START = 1; READ = rd; WRITE = wr; VMA = vma;
    AC_REF = ac; MATCH = m; ABRK_RD = ar; ABRK_WR = aw;
  endtask

  // While the sequencer is busy, this throws in a START that would trap if
  // it were accepted, so any leak is visible.
  task automatic maybe_intrude(input bit en, input logic [AW-1:0] vma);
    if (en && $urandom_range(0, 2) == 0) begin
      drive_start(1'b1, 1'($urandom), ~vma, 1'($urandom), 1'b1, 1'b1, 1'b1);
    end else begin
      START = 0;
    end
  endtask

  // MBOX transaction. Cycle c = 1 is the first cycle after the START edge.
  // ACK is pulsed in cycle ack_c and DONE in cycle done_c.
  task automatic run_mbox(input logic rd, input logic wr, input logic [AW-1:0] vma,
                          input logic m, input logic ar, input logic aw,
                          input int ack_c, input int done_c, input bit clr_at_exp,
                          input bit intrude);
    bit timeout;
    int mem_c, req_exp, reqn, donen, memc_obs, fmn, bad_lat, bad_busy;
    timeout  = (done_c > TO);
    mem_c    = timeout ? TO + 1 : done_c + 1;
    req_exp  = (ack_c < TO) ? ack_c : TO;
    reqn = 0; donen = 0; memc_obs = -1; fmn = 0; bad_lat = 0; bad_busy = 0;
    drive_start(rd, wr, vma, 1'b0, m, ar, aw);
    tick();
    for (int c = 1; c <= mem_c + 12; c++) begin
      if (MB_REQ) begin
        reqn++;
        if (MB_ADDR !== vma || MB_RD !== rd || MB_WR !== wr) bad_lat++;
      end
      if (MEM_DONE) begin
        donen++;
        if (memc_obs < 0) memc_obs = c;
      end
      if (FM_SEL) fmn++;
      if (BUSY !== (c <= mem_c)) bad_busy++;
      MB_ACK  = (c == ack_c) || (timeout && c == mem_c + 3);
      MB_DONE = (c == done_c) || (timeout && c == mem_c + 10);
      CLR_ERR = clr_at_exp && timeout && (c == TO);
      maybe_intrude(intrude && c <= mem_c, vma);
      tick();
    end
    START = 0; MB_ACK = 0; MB_DONE = 0; CLR_ERR = 0;
    if (clr_at_exp && timeout) exp_trap = 0;
    if (timeout) exp_nxm = 1;
    chk("req_cycles", reqn, req_exp);
    chk("mem_done_count", donen, 1);
    chk("mem_done_cycle", memc_obs, mem_c);
    chk("req_fields_stable", bad_lat, 0);
    chk("busy_window", bad_busy, 0);
    chk("no_fm_sel", fmn, 0);
    chk("addr_hold", MB_ADDR, vma);
    chk("rdwr_cleared", {MB_RD, MB_WR}, 2'b00);
    chk("nxm", NXM, exp_nxm);
    chk("trap", ADR_BRK_TRAP, exp_trap);
  endtask

  task automatic run_fm(input logic rd, input logic wr, input logic [AW-1:0] vma,
                        input logic m, input logic ar, input logic aw, input bit intrude);
    drive_start(rd, wr, vma, 1'b1, m, ar, aw);
    tick();
    maybe_intrude(intrude, vma);
    chk("fm_sel", {FM_SEL, MEM_DONE, MB_REQ, BUSY}, 4'b1101);
    chk("fm_adr", FM_ADR, vma[3:0]);
    tick();
    START = 0;
    chk("fm_end", {FM_SEL, MEM_DONE, MB_REQ, BUSY}, 4'b0000);
    chk("fm_adr_hold", FM_ADR, vma[3:0]);
    tick();
    chk("fm_quiet", {MEM_DONE, BUSY}, 2'b00);
  endtask

  task automatic run_trap(input logic rd, input logic wr, input logic [AW-1:0] vma,
                          input logic ac, input logic ar, input logic aw);
    drive_start(rd, wr, vma, ac, 1'b1, ar, aw);
    tick();
    START = 0;
    exp_trap = 1;
    chk("trap_outcome", {BUSY, MB_REQ, MEM_DONE, FM_SEL}, 4'b0000);
    chk("trap_flag", ADR_BRK_TRAP, 1'b1);
    tick();
    chk("trap_quiet", {BUSY, MB_REQ, MEM_DONE, FM_SEL}, 4'b0000);
  endtask

  task automatic run_nop(input logic [AW-1:0] vma);
    drive_start(1'b0, 1'b0, vma, 1'($urandom), 1'b1, 1'b1, 1'b1);
    tick();
    START = 0;
    chk("nop_idle", {BUSY, MB_REQ, MEM_DONE, FM_SEL, ADR_BRK_TRAP}, {4'b0000, exp_trap});
  endtask

  task automatic clear_errs();
    CLR_ERR = 1;
    tick();
    CLR_ERR = 0;
    exp_trap = 0;
    exp_nxm  = 0;
    chk("clr_err", {ADR_BRK_TRAP, NXM}, 2'b00);
  endtask

  initial begin
    // Reset state
    RESET_n = 1;
    #2 RESET_n = 0;
    #2;
    chk("reset_ctl", {MB_REQ, MB_RD, MB_WR, FM_SEL, BUSY, MEM_DONE, ADR_BRK_TRAP, NXM}, 8'h00);
    chk("reset_addr", {MB_ADDR, FM_ADR}, 0);
    repeat (2) @(posedge clk);
    #3 RESET_n = 1;
    tick();

    // Async reset while a request is outstanding
    drive_start(1'b1, 1'b1, 23'h7ABCDE, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    START = 0;
    tick();
    chk("req_before_reset", {MB_REQ, BUSY}, 2'b11);
    RESET_n = 0;
    #1;
    chk("async_reset_ctl", {MB_REQ, MB_RD, MB_WR, FM_SEL, BUSY, MEM_DONE, ADR_BRK_TRAP, NXM}, 8'h00);
    chk("async_reset_addr", {MB_ADDR, FM_ADR}, 0);
    #2 RESET_n = 1;
    tick();
    chk("idle_after_reset", {BUSY, MB_REQ}, 2'b00);

    // Directed cases
    run_fm(1'b1, 1'b0, 23'h000005, 1'b0, 1'b0, 1'b0, 1'b0);
    run_mbox(1'b0, 1'b1, 23'h012345, 1'b0, 1'b0, 1'b0, 4, 6, 1'b0, 1'b0);
    run_trap(1'b1, 1'b0, 23'h000777, 1'b0, 1'b1, 1'b0);
    run_mbox(1'b1, 1'b0, 23'h000777, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0, 1'b0);
    clear_errs();
    run_mbox(1'b1, 1'b0, 23'h055555, 1'b0, 1'b0, 1'b0, 1000, 1000, 1'b0, 1'b0);
    run_mbox(1'b1, 1'b0, 23'h0ABCD0, 1'b0, 1'b0, 1'b0, 2, 5, 1'b0, 1'b1);
    run_mbox(1'b1, 1'b1, 23'h333333, 1'b0, 1'b0, 1'b0, 1000, 1000, 1'b1, 1'b0);
    run_mbox(1'b1, 1'b0, 23'h000100, 1'b0, 1'b0, 1'b0, 3, TO, 1'b0, 1'b0);
    run_mbox(1'b0, 1'b1, 23'h000200, 1'b0, 1'b0, 1'b0, 3, TO + 1, 1'b0, 1'b0);
    run_mbox(1'b1, 1'b0, 23'h000300, 1'b0, 1'b0, 1'b0, TO, TO, 1'b0, 1'b0);
    run_nop(23'h000400);
    clear_errs();

    // Randomized transactions
    for (int t = 0; t < 150; t++) begin
      logic rd, wr, ac, m, ar, aw;
      logic [AW-1:0] v;
      int r, a, d;
      rd = 1'($urandom); wr = 1'($urandom); ac = 1'($urandom);
      m = 1'($urandom); ar = 1'($urandom); aw = 1'($urandom);
      v = AW'($urandom);
      if (!(rd | wr)) begin
        run_nop(v);
      end else if (m && ((rd && ar) || (wr && aw))) begin
        run_trap(rd, wr, v, ac, ar, aw);
      end else if (ac) begin
        run_fm(rd, wr, v, m, ar, aw, 1'($urandom));
      end else begin
        r = $urandom_range(0, 19);
        if (r == 0) begin
          a = 1000; d = 1000;
        end else if (r == 1) begin
          a = $urandom_range(1, 5); d = TO + $urandom_range(0, 1);
        end else if (r == 2) begin
          a = TO; d = TO + $urandom_range(0, 1);
        end else begin
          a = $urandom_range(1, 5); d = a + $urandom_range(0, 4);
        end
        run_mbox(rd, wr, v, m, ar, aw, a, d, 1'($urandom), 1'($urandom));
      end
      if ($urandom_range(0, 3) == 0) clear_errs();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
